imem_boot_loader: RTL
=====================

// Module: imem_boot_loader
// PURPOSE
//  Instruction memory plus byte-stream boot loader that sits directly upstream of the RISCV core.
//  After reset it receives a program image as a byte stream and writes it into on-chip instruction RAM.
//  The core is held in reset until the image is complete.
//  It then serves the core's fetch address combinationally with zero wait states, matching the core's single-cycle fetch.
// PARAMETERS
//  XLEN   32    data/address width of the core fetch port
//  DEPTH  1024  instruction RAM size in 32-bit words (power of 2)
//  AW     $clog2(DEPTH)  word-index width (derived, not overridable)
// PORTS
//  clk           in   1     single clock, rising edge
//  rst           in   1     synchronous, active-high reset
//  rx_valid_i    in   1     byte-stream valid
//  rx_data_i     in   8     byte-stream data
//  rx_ready_o    out  1     loader accepts a byte when rx_valid_i & rx_ready_o at clk edge
//  reload_i      in   1     1-cycle pulse: restart loading (honoured only in RUN)
//  IM_addr_i     in   XLEN  core fetch byte address (PC)
//  IM_data_o     out  XLEN  instruction word, combinational from IM_addr_i
//  core_rst_n_o  out  1     active-low reset to core; 0 until image loaded
//  load_done_o   out  1     1 in RUN
//  load_err_o    out  1     1 in ERR
//  word_cnt_o    out  AW+1  words written in the current load
// BEHAVIOUR
//  - Reset: state=HDR, byte_idx=0, word_cnt_o=0, core_rst_n_o=0, load_done_o=0, load_err_o=0, rx_ready_o=1.
//  - RAM contents are not cleared by reset.
//  - Image format: 4-byte little-endian header N (word count), then N words; each word is little-endian, byte 0 first.
//  - FSM, all outputs registered or decoded from state:
//    - HDR: rx_ready_o=1. On the 4th header byte, latch N.
//      - N==0 -> RUN.
//      - N>DEPTH -> ERR.
//      - Otherwise -> LOAD.
//    - LOAD: rx_ready_o=1. Bytes shift into a 32-bit assembler.
//      - On the edge accepting the 4th byte, RAM[word_cnt] is written and word_cnt increments.
//      - The new word is visible on IM_data_o from the next cycle.
//      - When word_cnt reaches N -> RUN on that same edge.
//    - RUN: rx_ready_o=0, core_rst_n_o=1, load_done_o=1.
//      - reload_i -> HDR: next cycle core_rst_n_o=0, word_cnt_o=0, byte_idx=0.
//    - ERR: rx_ready_o=0, core_rst_n_o=0, load_err_o=1. Exit only via rst.
//  - core_rst_n_o rises exactly 1 cycle after the edge that accepts the last byte (N>0), or after the last header byte (N==0).
//  - Fetch: index = IM_addr_i[AW+1:2]; IM_addr_i[1:0] ignored.
//    - If IM_addr_i[XLEN-1:AW+2] != 0, IM_data_o = 32'h0000_0013 (NOP); otherwise RAM word.
//  - rx_valid_i deasserted mid-word: assembler and byte_idx hold; there is no timeout.
//  - reload_i in HDR/LOAD/ERR: ignored.
//  - rst mid-load: partial word discarded, RAM keeps already-written words, core reset reasserted.
//  - byte_idx wraps 3->0 on each completed word; word_cnt_o saturates at N and never exceeds DEPTH.
// STRUCTURE
//  - Shared package riscv_pkg holds:
//    - XLEN
//    - NOP_INSTR = 32'h0000_0013
//    - loader state enum {HDR, LOAD, RUN, ERR}
//  - Sub-module imem_ram: DEPTH x 32 array with 1 synchronous write port and 1 combinational read port.
//  - The FSM, byte assembler and counters live in imem_boot_loader.
// TESTING
//  - Reset then stream header 02 00 00 00 + 13 05 10 00 + 93 05 20 00:
//    - RAM[0]=32'h00100513, RAM[1]=32'h00200593.
//    - core_rst_n_o=1 one cycle after the last byte; word_cnt_o=2.
//  - Header with N=0: RUN one cycle after the 4th header byte; rx_ready_o=0; no RAM write.
//  - Header N=DEPTH+1: load_err_o=1, core_rst_n_o stays 0, rx_ready_o=0.
//    - reload_i pulses are ignored; only rst clears the error.
//  - Gaps: rx_valid_i toggled 1/0 every cycle during LOAD: same RAM contents as the gap-free case.
//  - Fetch: IM_addr_i=32'h4 -> RAM[1], IM_addr_i=32'h6 -> RAM[1]; IM_addr_i=DEPTH*4 -> 32'h00000013.
//  - Reload and reset:
//    - reload_i in RUN: core_rst_n_o=0 next cycle, word_cnt_o=0; a new 1-word image overwrites RAM[0].
//    - rst asserted after 5 payload bytes: state HDR, RAM[0] retains the loaded word, core_rst_n_o=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core-side definitions: fetch width, canonical NOP, boot loader states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        ERR  = 2'd3
    } ldr_state_t;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x 32 instruction RAM: one synchronous write port, one combinational read port.
// Latency: write lands on the clock edge, read is combinational (0 cycles).
// Backpressure: none, always accepts a write.
module imem_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // No reset: the image must survive a core/loader reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader plus instruction RAM; holds the core in reset until the image is in.
// Latency: word visible on IM_data_o the cycle after its 4th byte; fetch is combinational.
// Backpressure: rx_ready_o high in HDR/LOAD, low in RUN/ERR; rx_valid_i gaps simply stall the assembler.
module imem_boot_loader #(
    parameter  int XLEN  = riscv_pkg::XLEN,
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx_valid_i,
    input  logic [7:0]      rx_data_i,
    output logic            rx_ready_o,
    input  logic            reload_i,
    input  logic [XLEN-1:0] IM_addr_i,
    output logic [XLEN-1:0] IM_data_o,
    output logic            core_rst_n_o,
    output logic            load_done_o,
    output logic            load_err_o,
    output logic [AW:0]     word_cnt_o
);

    import riscv_pkg::*;

    ldr_state_t  state;
    logic [1:0]  byte_idx;
    logic [23:0] asm_lo;
    logic [AW:0] n_words;
    logic [AW:0] word_cnt;
    logic [AW:0] cnt_inc;
    logic [31:0] full_word;
    logic        accept;
    logic        last_byte;
    logic        ram_we;
    logic [31:0] ram_rdata;
    logic        addr_hi_set;
    logic        unused_addr_lsb;

    // Bytes arrive LSB first, so the 4th byte completes the word at the top.
    assign full_word = {rx_data_i, asm_lo};
    assign accept    = rx_valid_i & rx_ready_o;
    assign last_byte = accept & (byte_idx == 2'd3);
    assign cnt_inc   = word_cnt + {{AW{1'b0}}, 1'b1};
    assign ram_we    = (state == LOAD) & last_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HDR;
            byte_idx     <= 2'd0;
            asm_lo       <= '0;
            n_words      <= '0;
            word_cnt     <= '0;
            rx_ready_o   <= 1'b1;
            core_rst_n_o <= 1'b0;
            load_done_o  <= 1'b0;
            load_err_o   <= 1'b0;
        end else begin
            case (state)
                HDR, LOAD: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 2'd1;
                        asm_lo   <= {rx_data_i, asm_lo[23:8]};
                    end
                    if (last_byte && state == HDR) begin
                        if (full_word == '0) begin
                            state        <= RUN;
                            rx_ready_o   <= 1'b0;
                            core_rst_n_o <= 1'b1;
                            load_done_o  <= 1'b1;
                        end else if (full_word > 32'(DEPTH)) begin
                            state      <= ERR;
                            rx_ready_o <= 1'b0;
                            load_err_o <= 1'b1;
                        end else begin
                            state   <= LOAD;
                            n_words <= full_word[AW:0];
                        end
                    end else if (last_byte) begin
                        word_cnt <= cnt_inc;
                        if (cnt_inc == n_words) begin
                            state        <= RUN;
                            rx_ready_o   <= 1'b0;
                            core_rst_n_o <= 1'b1;
                            load_done_o  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (reload_i) begin
                        state        <= HDR;
                        byte_idx     <= 2'd0;
                        word_cnt     <= '0;
                        rx_ready_o   <= 1'b1;
                        core_rst_n_o <= 1'b0;
                        load_done_o  <= 1'b0;
                    end
                end
                default: ;  // ERR is sticky until rst
            endcase
        end
    end

    assign word_cnt_o = word_cnt;

    imem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (word_cnt[AW-1:0]),
        .wdata (full_word),
        .raddr (IM_addr_i[AW+1:2]),
        .rdata (ram_rdata)
    );

    // Fetches outside the RAM window return a NOP rather than aliasing.
    assign addr_hi_set     = |IM_addr_i[XLEN-1:AW+2];
    assign IM_data_o       = addr_hi_set ? XLEN'(NOP_INSTR) : XLEN'(ram_rdata);
    assign unused_addr_lsb = ^IM_addr_i[1:0];

endmodule
